mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one 5x5 signed Booth multiplier (start/Done handshake, 10-bit product) among N_REQ requesters.
- Round-robin arbitration; latches the winner's operands and pulses the multiplier start.
- Detects completion and returns the product to the winner with a one-cycle acknowledge.
- Watchdog reports an error if the multiplier never signals Done.
- Sits between client FSMs and the multiplier top; the multiplier is instantiated beside it, not inside it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 5, operand width; product width is 2*W.
- TIMEOUT, 64, max cycles in WAIT before abort (>= 2*W+4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per client; held until its ack.
- x_in  in  N_REQ*W  client operands X, slice i = bits [i*W +: W].
- y_in  in  N_REQ*W  client operands Y, same slicing.
- grant  out  N_REQ  one-hot; owner of the multiplier from capture until ack.
- ack  out  N_REQ  one-cycle pulse to the owner; res_out/err valid this cycle.
- res_out  out  2*W  product returned to the owner.
- err  out  1  with ack: 1 = timeout, res_out forced to 0.
- busy  out  1  FSM not in IDLE.
- mul_start  out  1  start pulse to multiplier.
- mul_x, mul_y  out  W each  operands to multiplier.
- mul_done  in  1  multiplier Done (level; may stay high until next start).
- mul_result  in  2*W  multiplier product.

Behaviour:
- Reset (async): state IDLE, rr_ptr=0. grant, ack, res_out, err, busy, mul_start, mul_x, mul_y all 0. done_q=0, wd_cnt=0.
- State IDLE:
  - If any req: pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Register owner index; grant[owner]=1.
  - Latch x_in/y_in slices into mul_x/mul_y; go LAUNCH.
  - Operands are captured at this edge; the client may change them afterwards.
- State LAUNCH: mul_start=1 for exactly this cycle; wd_cnt=0; go WAIT.
- State WAIT:
  - Completion is a rising edge of mul_done (mul_done=1 && done_q=0); done_q is mul_done registered every cycle.
  - A Done level left high from the previous op is therefore ignored.
  - On edge: capture mul_result into res_out, err=0, go RESP.
  - Otherwise wd_cnt++. When wd_cnt==TIMEOUT-1 with no edge: res_out=0, err=1, go RESP.
- State RESP:
  - ack[owner]=1 for one cycle; grant cleared on exit.
  - rr_ptr = (owner+1) mod N_REQ; go IDLE.
  - res_out and err hold until the next RESP.
- Timing: req seen in IDLE -> start pulse 1 cycle later -> ack 1 cycle after the Done edge is sampled. Minimum overhead is 3 cycles plus multiplier latency.
- grant is stable through LAUNCH/WAIT/RESP. mul_x/mul_y are held from capture until the next capture.
- Simultaneous requests: only one grant; the others wait. With all clients continuously requesting, service order is 0,1,2,3,0,... with no starvation.
- A req still high in the cycle after its ack is a new request, served at its next round-robin turn.
- req dropping before grant: the request is withdrawn, no effect. req dropping after grant: ignored; the op completes and ack is still pulsed.
- mul_done edge outside WAIT: ignored; done_q still tracks it.
- rst mid-operation: immediate return to reset values, no ack issued. The multiplier shares rst and is reset together.
- Arithmetic: none in the arbiter; res_out is a pass-through of the signed 2*W product.

Decomposition:
- Shared package mult_pkg:
  - FSM state encoding (IDLE, LAUNCH, WAIT, RESP; 2 bits).
  - Constants MUL_W=5 and PROD_W=10, used by the multiplier and the arbiter defaults.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs req vector and rr_ptr; outputs one-hot winner, index and valid. Reused by later arbiters.

Test Plan:
- Single client 0: X=5'b11101 (-3), Y=5'b00111 (7), multiplier instantiated. Expect exactly one mul_start pulse, then ack[0] with res_out=10'b1111101011 (-21), err=0; grant[0] high from capture through the ack cycle.
- All four clients request at once with X=i+1, Y=2. Expect acks in order 0,1,2,3 with products 2,4,6,8. Continuous re-request must give order 0,1,2,3,0,1.
- Done held high between ops (the multiplier keeps Done high after finishing). Back-to-back requests from client 1: second op must wait for a fresh Done edge. No early ack with the stale product.
- Stub multiplier never raises Done, TIMEOUT=64: expect ack with err=1 and res_out=0 exactly 64 cycles after the WAIT entry, then the next pending client is served.
- Assert rst while in WAIT: all outputs 0 at once (asynchronously), no ack issued. After release, a pending req from client 2 is served first (rr_ptr=0 scan finds 2).
- Client changes x_in the cycle after grant (X=-16, Y=-16 captured, then X changed to 0): expect res_out=256 (10'b0100000000), proving operands were latched at capture.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter and its datapath neighbours:
// FSM encoding, default widths and a small index-wrap helper.
package mult_pkg;

  localparam int MUL_W  = 5;
  localparam int PROD_W = 2 * MUL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // base must already be < n; off < n
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// wrapping modulo N.
module rr_pick
  import mult_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[rr_wrap(int'(ptr), k, N)]) begin
        valid                            = 1'b1;
        idx                              = IW'(rr_wrap(int'(ptr), k, N));
        onehot[rr_wrap(int'(ptr), k, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one start/done multiplier among N_REQ clients, with
// operand capture, Done-edge completion and a watchdog that aborts a stuck op.
//
// state  | meaning
// IDLE   | no owner; pick next requester, latch its operands
// LAUNCH | pulse mul_start, clear watchdog
// WAIT   | wait for rising edge of mul_done or watchdog expiry
// RESP   | ack the owner with res_out/err, advance rr pointer
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = MUL_W,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   x_in,
  input  logic [N_REQ*W-1:0]   y_in,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     ack,
  output logic [2*W-1:0]       res_out,
  output logic                 err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [W-1:0]         mul_x,
  output logic [W-1:0]         mul_y,
  input  logic                 mul_done,
  input  logic [2*W-1:0]       mul_result
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             err_q, err_d;
  logic [W-1:0]     mul_x_q, mul_x_d;
  logic [W-1:0]     mul_y_q, mul_y_d;
  logic [CW-1:0]    wd_cnt_q, wd_cnt_d;
  logic             done_q;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             done_edge;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // A Done level left over from the previous op must not complete this one.
  assign done_edge = mul_done && !done_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    res_d    = res_q;
    err_d    = err_q;
    mul_x_d  = mul_x_q;
    mul_y_d  = mul_y_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = pick_onehot;
          mul_x_d = x_in[int'(pick_idx)*W +: W];
          mul_y_d = y_in[int'(pick_idx)*W +: W];
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_edge) begin
          res_d   = mul_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        grant_d  = '0;
        rr_ptr_d = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      mul_x_q  <= '0;
      mul_y_q  <= '0;
      wd_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      res_q    <= res_d;
      err_q    <= err_d;
      mul_x_q  <= mul_x_d;
      mul_y_q  <= mul_y_d;
      wd_cnt_q <= wd_cnt_d;
      done_q   <= mul_done;
    end
  end

  assign grant     = grant_q;
  assign ack       = (state_q == ST_RESP) ? grant_q : '0;
  assign res_out   = res_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign mul_start = (state_q == ST_LAUNCH);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural start/done multiplier
// that keeps Done high after finishing and can be stalled to force the watchdog.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 5;
  localparam int LAT = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] x_in = '0;
  logic [N*W-1:0] y_in = '0;
  logic [N-1:0]   grant, ack;
  logic [2*W-1:0] res_out;
  logic           err, busy, mul_start;
  logic [W-1:0]   mul_x, mul_y;
  logic           mul_done;
  logic [2*W-1:0] mul_result;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int grant_bad = 0;
  logic stub_never = 1'b0;

  mult_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .grant(grant), .ack(ack), .res_out(res_out), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: Done drops two edges after start, rises LAT later, then stays high.
  int             m_cyc;
  logic           m_active;
  logic [2*W-1:0] m_prod;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done <= 1'b0; mul_result <= '0; m_cyc <= 0; m_active <= 1'b0; m_prod <= '0;
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cyc    <= 0;
      m_prod   <= $signed({{W{mul_x[W-1]}}, mul_x}) * $signed({{W{mul_y[W-1]}}, mul_y});
    end else if (m_active) begin
      m_cyc <= m_cyc + 1;
      if (m_cyc == 1) mul_done <= 1'b0;
      if (m_cyc == LAT && !stub_never) begin
        mul_done   <= 1'b1;
        mul_result <= m_prod;
        m_active   <= 1'b0;
      end
    end
  end

  logic [N-1:0] prev_grant;
  logic         prev_busy;
  always @(negedge clk) begin
    if (mul_start) n_start++;
    if (!rst) begin
      if (!busy && grant != '0) grant_bad++;
      if (busy && $countones(grant) != 1) grant_bad++;
      if (busy && prev_busy && grant != prev_grant) grant_bad++;
    end
    prev_grant = grant;
    prev_busy  = busy && !rst;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int c, input logic [W-1:0] x, input logic [W-1:0] y);
    x_in[c*W +: W] = x;
    y_in[c*W +: W] = y;
  endtask

  task automatic wait_ack(input string nm, output logic ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no ack within 200 cycles, required an ack", nm);
    end
  endtask

  task automatic wait_start(input string nm, output logic ok);
    int i;
    ok = 1'b0; i = 0;
    while (!ok && i < 100) begin
      @(negedge clk);
      i++;
      if (mul_start) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no mul_start within 100 cycles, required a start pulse", nm);
    end
  endtask

  task automatic run_op(input int c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp_res, input string nm);
    int s0, cyc;
    logic ok;
    @(negedge clk);
    s0 = n_start;
    set_ops(c, x, y);
    req[c] = 1'b1;
    wait_ack(nm, ok, cyc);
    req[c] = 1'b0;
    if (ok) begin
      chk({nm, "_ack"},    32'(ack),     32'(1 << c));
      chk({nm, "_grant"},  32'(grant),   32'(1 << c));
      chk({nm, "_res"},    32'(res_out), 32'(exp_res));
      chk({nm, "_err"},    32'(err),     32'd0);
      chk({nm, "_starts"}, 32'(n_start - s0), 32'd1);
    end
    @(negedge clk);
    chk({nm, "_ack_pulse"}, 32'(ack), 32'd0);
  endtask

  typedef struct {
    int             c;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] res;
  } vec_t;

  vec_t vecs[7];
  int   ord[6];
  logic [2*W-1:0] prods[6];

  initial begin
    logic ok;
    int   cyc;

    vecs[0] = '{0, 5'b11101, 5'b00111, 10'b1111101011}; // -3*7 = -21
    vecs[1] = '{1, 5'b10000, 5'b10000, 10'h100};        // -16*-16 = 256
    vecs[2] = '{2, 5'b01111, 5'b01111, 10'h0E1};        // 15*15 = 225
    vecs[3] = '{3, 5'b10000, 5'b01111, 10'h310};        // -16*15 = -240
    vecs[4] = '{0, 5'b00000, 5'b11011, 10'h000};        // 0*-5
    vecs[5] = '{1, 5'b11111, 5'b11111, 10'h001};        // -1*-1
    vecs[6] = '{2, 5'b00111, 5'b11000, 10'h3C8};        // 7*-8 = -56
    ord   = '{0, 1, 2, 3, 0, 1};
    prods = '{10'd2, 10'd4, 10'd6, 10'd8, 10'd2, 10'd4};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_res", 32'(res_out), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(mul_start), 0);
    chk("rst_mulxy", 32'({mul_x, mul_y}), 0);
    rst = 1'b0;

    // all four at once, continuous re-request
    @(negedge clk);
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 5'd2);
    req = '1;
    for (int k = 0; k < 6; k++) begin
      wait_ack("rr_order", ok, cyc);
      if (ok) begin
        chk($sformatf("rr_ack%0d", k), 32'(ack), 32'(1 << ord[k]));
        chk($sformatf("rr_res%0d", k), 32'(res_out), 32'(prods[k]));
      end
      if (k == 5) req = '0;
    end

    // single-client vectors
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].c, vecs[i].x, vecs[i].y, vecs[i].res, $sformatf("vec%0d", i));

    // back-to-back on client 1 with Done still high from the first op
    @(negedge clk);
    set_ops(1, 5'd3, 5'd5);
    req[1] = 1'b1;
    wait_ack("b2b_first", ok, cyc);
    if (ok) chk("b2b_first_res", 32'(res_out), 32'd15);
    set_ops(1, 5'b11110, 5'd6);
    chk("b2b_done_held", 32'(mul_done), 32'd1);
    wait_ack("b2b_second", ok, cyc);
    req[1] = 1'b0;
    if (ok) begin
      chk("b2b_second_ack", 32'(ack), 32'b0010);
      chk("b2b_second_res", 32'(res_out), 32'h3F4); // -2*6 = -12
    end

    // operands latched at capture
    @(negedge clk);
    set_ops(1, 5'b10000, 5'b10000);
    req[1] = 1'b1;
    wait_start("latch", ok);
    set_ops(1, 5'd0, 5'b10000);
    wait_ack("latch", ok, cyc);
    req[1] = 1'b0;
    if (ok) chk("latch_res", 32'(res_out), 32'h100);

    // watchdog: stalled multiplier, client 3 pending behind client 2
    @(negedge clk);
    stub_never = 1'b1;
    set_ops(2, 5'd1, 5'd1);
    set_ops(3, 5'b11101, 5'b11101);
    req[2] = 1'b1;
    wait_start("wd", ok);
    req[3] = 1'b1;
    wait_ack("wd", ok, cyc);
    req[2] = 1'b0;
    stub_never = 1'b0;
    if (ok) begin
      chk("wd_cycles", 32'(cyc), 32'd65);
      chk("wd_ack", 32'(ack), 32'b0100);
      chk("wd_err", 32'(err), 32'd1);
      chk("wd_res", 32'(res_out), 32'd0);
    end
    wait_ack("wd_next", ok, cyc);
    req[3] = 1'b0;
    if (ok) begin
      chk("wd_next_ack", 32'(ack), 32'b1000);
      chk("wd_next_res", 32'(res_out), 32'd9);
      chk("wd_next_err", 32'(err), 32'd0);
    end

    // leave rr_ptr at 3, then reset while client 3 is in WAIT
    run_op(2, 5'd2, 5'd3, 10'd6, "pre_rst");
    req[3] = 1'b1; req[2] = 1'b1;
    wait_start("mid_rst", ok);
    repeat (2) @(negedge clk);
    chk("mid_rst_owner", 32'(grant), 32'b1000);
    #1 rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_ack", 32'(ack), 0);
    chk("async_res", 32'(res_out), 0);
    chk("async_mulx", 32'(mul_x), 0);
    @(negedge clk);
    chk("rst_hold_ack", 32'(ack), 0);
    rst = 1'b0;
    wait_ack("post_rst", ok, cyc);
    req = '0;
    if (ok) begin
      chk("post_rst_ack", 32'(ack), 32'b0100);
      chk("post_rst_res", 32'(res_out), 32'd6);
    end

    @(negedge clk);
    chk("grant_protocol", 32'(grant_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
